// File: rtl/bcd_stopwatch_ctrl_if.sv
// bcd_stopwatch_ctrl_if: command/status bundle between the front panel and the stopwatch controller.
// Commands (master -> slave): start_i, stop_i, clear_i, lap_i (level-sampled each clock edge).
// Status   (slave -> master): cnt_o / lap_cnt_o (4-digit BCD), lap_valid_o, running_o, overflow_o.
interface bcd_stopwatch_ctrl_if;
  logic        start_i;
  logic        stop_i;
  logic        clear_i;
  logic        lap_i;
  logic [15:0] cnt_o;
  logic [15:0] lap_cnt_o;
  logic        lap_valid_o;
  logic        running_o;
  logic        overflow_o;
  modport master (
    output start_i, stop_i, clear_i, lap_i,
    input  cnt_o, lap_cnt_o, lap_valid_o, running_o, overflow_o
  );
  modport slave (
    input  start_i, stop_i, clear_i, lap_i,
    output cnt_o, lap_cnt_o, lap_valid_o, running_o, overflow_o
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: four-digit BCD stopwatch with start/stop/clear/lap control and a TICK_DIV prescaler.
// Ports: clk (rising-edge clock), rst_n (async active-low reset),
//        bus (slave modport: command levels in; live count, lap capture, running and overflow status out).
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_stopwatch_ctrl_if.slave  bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d, lap_q, lap_d, inc;
  logic          lap_valid_q, lap_valid_d, running_q, overflow_q;
  logic [3:0]    cy;
  logic          advance, tick;
  // A stop or clear on the same edge freezes the prescaler, so a due tick is dropped.
  assign advance = (state_q == RUN) && !bus.stop_i && !bus.clear_i;
  assign tick    = advance && (presc_q == TOP);
  // Ripple-carry BCD incrementer: each digit wraps 9->0 and carries, all within one cycle.
  assign cy[0] = 1'b1;
  for (genvar g = 0; g < 4; g++) begin : g_dig
    logic [3:0] d;
    assign d = cnt_q[4*g +: 4];
    assign inc[4*g +: 4] = cy[g] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    if (g < 3) begin : g_cy
      assign cy[g+1] = cy[g] & (d == 4'd9);
    end
  end
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    lap_d       = lap_q;
    lap_valid_d = lap_valid_q;
    if (advance) presc_d = tick ? '0 : presc_q + PW'(1);
    if (bus.lap_i && (state_q == RUN || state_q == PAUSE)) begin
      lap_d       = cnt_q;
      lap_valid_d = 1'b1;
    end
    case (state_q)
      IDLE, PAUSE: if (bus.start_i && !bus.stop_i) state_d = RUN;
      RUN: begin
        if (bus.stop_i) state_d = PAUSE;
        else if (tick) begin
          if (cnt_q == 16'h9999) state_d = OVF;
          else cnt_d = inc;
        end
      end
      default: ;
    endcase
    if (bus.clear_i) begin
      state_d     = IDLE;
      presc_d     = '0;
      cnt_d       = '0;
      lap_d       = '0;
      lap_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      cnt_q       <= '0;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      lap_q       <= lap_d;
      lap_valid_q <= lap_valid_d;
      running_q   <= (state_d == RUN);
      overflow_q  <= (state_d == OVF);
    end
  end
  assign bus.cnt_o       = cnt_q;
  assign bus.lap_cnt_o   = lap_q;
  assign bus.lap_valid_o = lap_valid_q;
  assign bus.running_o   = running_q;
  assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: drives a TICK_DIV=4 and a TICK_DIV=1 stopwatch with identical commands against a decimal reference model.
module tb_bcd_stopwatch_ctrl;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVF = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_err = 0;
  int st[2], n[2], ph[2], lapn[2];
  bit lapv[2];
  int divs[2] = '{4, 1};
  bcd_stopwatch_ctrl_if a ();
  bcd_stopwatch_ctrl_if b ();
  bcd_stopwatch_ctrl #(.TICK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(a));
  bcd_stopwatch_ctrl #(.TICK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic logic [34:0] got(input int k);
    return (k == 1) ? {b.cnt_o, b.lap_cnt_o, b.lap_valid_o, b.running_o, b.overflow_o}
                    : {a.cnt_o, a.lap_cnt_o, a.lap_valid_o, a.running_o, a.overflow_o};
  endfunction
  function automatic logic [34:0] expv(input int k);
    return {to_bcd(n[k]), to_bcd(lapn[k]), lapv[k], st[k] == S_RUN, st[k] == S_OVF};
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = S_IDLE; n[k] = 0; ph[k] = 0; lapn[k] = 0; lapv[k] = 0;
    end
  endtask
  // Reference: count kept as a plain integer, ph counts qualifying RUN cycles since the last tick.
  task automatic model(input int k, input bit s, input bit t, input bit c, input bit l);
    if (c) begin
      st[k] = S_IDLE; n[k] = 0; ph[k] = 0; lapn[k] = 0; lapv[k] = 0;
    end else begin
      if (l && (st[k] == S_RUN || st[k] == S_PAUSE)) begin
        lapn[k] = n[k]; lapv[k] = 1;
      end
      if ((st[k] == S_IDLE || st[k] == S_PAUSE) && s && !t) st[k] = S_RUN;
      else if (st[k] == S_RUN && t) st[k] = S_PAUSE;
      else if (st[k] == S_RUN) begin
        ph[k]++;
        if (ph[k] == divs[k]) begin
          ph[k] = 0;
          if (n[k] == 9999) st[k] = S_OVF;
          else n[k]++;
        end
      end
    end
  endtask
  task automatic step(input bit s, input bit t, input bit c, input bit l);
    a.start_i = s; a.stop_i = t; a.clear_i = c; a.lap_i = l;
    b.start_i = s; b.stop_i = t; b.clear_i = c; b.lap_i = l;
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int k = 0; k < 2; k++) model(k, s, t, c, l);
    #1;
  endtask
  task automatic test_reset();
    step(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got(k) !== 35'd0) begin n_err++; $display("FAIL reset_idle dut%0d: got %h required 0", k, got(k)); end
    end
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    n_cmp++;
    if (a.running_o !== 1'b1 || a.cnt_o !== 16'h0000) begin
      n_err++; $display("FAIL start_run: running %b cnt %h required 1 0000", a.running_o, a.cnt_o);
    end
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0);
      if (i == 3 || i == 4 || i == 8) begin
        n_cmp++;
        if (a.cnt_o !== ((i == 3) ? 16'h0000 : (i == 4) ? 16'h0001 : 16'h0002)) begin
          n_err++; $display("FAIL first_count edge%0d: got %h", i, a.cnt_o);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (got(k) !== expv(k)) begin n_err++; $display("FAIL first_count_model dut%0d: got %h required %h", k, got(k), expv(k)); end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got(k) !== 35'd0) begin n_err++; $display("FAIL async_reset dut%0d: got %h required 0", k, got(k)); end
    end
    step(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask
  task automatic test_carry();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 1; i <= 1000; i++) begin
      bit bad;
      step(0, 0, 0, 0);
      bad = 0;
      for (int d = 0; d < 4; d++) if (b.cnt_o[4*d +: 4] > 4'd9) bad = 1;
      n_cmp++;
      if (bad) begin n_err++; $display("FAIL digit_range: cnt %h", b.cnt_o); end
      n_cmp++;
      if (got(1) !== expv(1)) begin n_err++; $display("FAIL carry_model: got %h required %h", got(1), expv(1)); end
      if (i == 999 || i == 1000) begin
        n_cmp++;
        if (b.cnt_o !== ((i == 999) ? 16'h0999 : 16'h1000)) begin
          n_err++; $display("FAIL carry_ripple step%0d: got %h", i, b.cnt_o);
        end
      end
    end
  endtask
  task automatic test_pause();
    step(0, 0, 1, 0);
    for (int e = 0; e <= 13; e++) begin
      step(e == 0 || e == 10, e == 2, 0, 0);
      n_cmp++;
      if (a.cnt_o !== ((e == 13) ? 16'h0001 : 16'h0000)) begin
        n_err++; $display("FAIL pause_continuity edge%0d: got %h", e, a.cnt_o);
      end
      n_cmp++;
      if (got(0) !== expv(0)) begin n_err++; $display("FAIL pause_model edge%0d: got %h required %h", e, got(0), expv(0)); end
    end
  endtask
  task automatic test_stop_on_tick();
    step(0, 0, 1, 0);
    for (int e = 0; e <= 8; e++) begin
      step(e == 0 || e == 7, e == 4, 0, 0);
      if (e >= 4) begin
        n_cmp++;
        if (a.cnt_o !== ((e == 8) ? 16'h0001 : 16'h0000) || a.running_o !== (e >= 7)) begin
          n_err++; $display("FAIL stop_on_tick edge%0d: cnt %h running %b", e, a.cnt_o, a.running_o);
        end
      end
    end
  endtask
  task automatic test_overflow();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 9999; i++) step(0, 0, 0, 0);
    n_cmp++;
    if (b.cnt_o !== 16'h9999 || b.running_o !== 1'b1 || b.overflow_o !== 1'b0) begin
      n_err++; $display("FAIL ovf_pre: cnt %h run %b ovf %b", b.cnt_o, b.running_o, b.overflow_o);
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (b.cnt_o !== 16'h9999 || b.running_o !== 1'b0 || b.overflow_o !== 1'b1) begin
      n_err++; $display("FAIL ovf_enter: cnt %h run %b ovf %b", b.cnt_o, b.running_o, b.overflow_o);
    end
    step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 1); step(1, 0, 0, 1);
    n_cmp++;
    if (got(1) !== {16'h9999, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL ovf_sticky: got %h", got(1));
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got(k) !== expv(k)) begin n_err++; $display("FAIL ovf_model dut%0d: got %h required %h", k, got(k), expv(k)); end
    end
    step(0, 0, 1, 0);
    n_cmp++;
    if (got(1) !== 35'd0) begin n_err++; $display("FAIL ovf_clear: got %h required 0", got(1)); end
  endtask
  task automatic test_priority();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 168; i++) step(0, 0, 0, 0);
    n_cmp++;
    if (a.cnt_o !== 16'h0042) begin n_err++; $display("FAIL prio_setup: cnt %h required 0042", a.cnt_o); end
    step(1, 1, 0, 1);
    n_cmp++;
    if (got(0) !== {16'h0042, 16'h0042, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL prio_stop_lap: got %h", got(0));
    end
    step(0, 0, 1, 1);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got(k) !== 35'd0) begin n_err++; $display("FAIL prio_clear_lap dut%0d: got %h required 0", k, got(k)); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(31) == 0, $urandom_range(3) == 0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (got(k) !== expv(k)) begin n_err++; $display("FAIL random dut%0d cyc%0d: got %h required %h", k, i, got(k), expv(k)); end
      end
    end
  endtask
  initial begin
    model_reset();
    #1;
    test_reset();
    test_carry();
    test_pause();
    test_stop_on_tick();
    test_overflow();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
